and_eval_arbiter: RTL
=====================

Name: and_eval_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one cosimulated WIDTH-bit AND evaluation resource between NREQ requesters.
- The resource is a bank of WIDTH AND-gate proxies driven through res_a/res_b and returning res_y.
- The block grants one requester at a time, holds its operands on the resource for LAT settle cycles, captures the result and returns it over a valid/ready handshake.
- It sits between the testbench-side requesters and the proxy bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- LAT, 2, settle cycles between driving operands and sampling res_y (1..15).
- COUNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  NREQ  per-requester request; held with operands until own gnt seen.
- a_in  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B, same packing.
- gnt  output  NREQ  one-hot, one-cycle pulse: operands of that requester were sampled.
- rsp_valid  output  NREQ  one-hot response valid.
- rsp_ready  input  NREQ  per-requester response accept.
- rsp_data  output  WIDTH  result for the requester flagged by rsp_valid.
- res_a  output  WIDTH  operand A to the proxy bank.
- res_b  output  WIDTH  operand B to the proxy bank.
- res_y  input  WIDTH  result from the proxy bank.
- busy  output  1  high whenever state != IDLE.
- txn_count  output  COUNT_W  completed transactions, wraps.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, res_a=0, res_b=0, busy=0, txn_count=0, state=IDLE, RR pointer=0, cnt=0.
- States: IDLE, WAIT, RESP.
- IDLE, req==0: nothing changes.
- IDLE, req!=0, at the edge:
  - Pick the winner: first set bit searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - Latch the winner index; latch its a/b slices into res_a/res_b.
  - gnt[winner]=1 for exactly the next cycle.
  - ptr <= (winner+1) mod NREQ; cnt <= LAT; go to WAIT.
- WAIT:
  - res_a/res_b held stable.
  - Each edge: if cnt==1, sample res_y into rsp_data, set rsp_valid[winner]=1 and go to RESP; else cnt <= cnt-1.
  - WAIT lasts exactly LAT cycles, so rsp_valid rises LAT cycles after gnt rises.
- RESP:
  - rsp_valid and rsp_data held until rsp_ready[winner]=1 at an edge.
  - On accept: rsp_valid <= 0, txn_count <= txn_count+1 (mod 2^COUNT_W), go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- No new grant while busy. Requests arriving during WAIT/RESP wait, and are evaluated at the first IDLE edge after RESP completes.
- Minimum spacing between consecutive grants: LAT+2 cycles (the IDLE edge is re-entered each time).
- res_a/res_b keep their last values in IDLE; the resource output is only sampled in WAIT.
- A requester dropping req before its grant simply withdraws. req changing during WAIT/RESP has no effect on the current transaction.
- Reset mid-transaction, any state: the transaction is dropped, no rsp_valid is produced and all reset values apply. The next grant search starts at requester 0.
- gnt and rsp_valid are never asserted simultaneously for the same transaction. At most one bit of either is ever set.
- Parameters outside their stated range are a simulation-time fatal error in an initial check.

Test Plan:
- Single request, LAT=2: req[0]=1, a=0xF0, b=0x3C.
  - gnt=0001 for one cycle; rsp_valid[0] rises 2 cycles after gnt with rsp_data=0x30.
  - rsp_ready[0]=1 → txn_count=1, busy falls next cycle.
- Simultaneous from reset: req=1111 held, each requester dropping req after its gnt and acking immediately.
  - Grant order 0,1,2,3; results equal each a&b (e.g. 0xFF&0x0F=0x0F).
  - txn_count=4.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles after rsp_valid[1] while req[3]=1.
  - rsp_valid[1] and rsp_data stay stable and busy=1; gnt[3] stays 0.
  - gnt[3] fires 1 cycle after rsp_ready[1] is accepted.
- Fairness: req[0] and req[2] held permanently → grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Reset during WAIT (LAT=4, rst asserted 2 cycles after gnt[0]):
  - All outputs at reset values; no rsp_valid appears.
  - With req=0110 afterwards, the first grant goes to requester 1.
- Counter wrap, COUNT_W=4: 16 completed transactions → txn_count returns to 0x0; the 17th completion gives 0x1.

Source files
------------

// File: rtl/and_eval_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit AND evaluation resource
// between NREQ requesters, returning each result over a valid/ready handshake.
module and_eval_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int LAT     = 2,
   parameter int COUNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   a_in,
   input  logic [NREQ*WIDTH-1:0]   b_in,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [WIDTH-1:0]        rsp_data,
   output logic [WIDTH-1:0]        res_a,
   output logic [WIDTH-1:0]        res_b,
   input  logic [WIDTH-1:0]        res_y,
   output logic                    busy,
   output logic [COUNT_W-1:0]      txn_count
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   if (NREQ < 2 || NREQ > 8 || LAT < 1 || LAT > 15 || WIDTH < 1 || COUNT_W < 1) begin : g_param_check
      $fatal(1, "and_eval_arbiter: parameter out of range (NREQ=%0d LAT=%0d WIDTH=%0d COUNT_W=%0d)",
             NREQ, LAT, WIDTH, COUNT_W);
   end

   logic [1:0]        state;
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  wid;
   logic [3:0]        cnt;

   logic              found;
   logic [PTR_W-1:0]  win_idx;
   logic [NREQ-1:0]   win_onehot;
   logic [NREQ-1:0]   wid_onehot;
   int                idx;

   // Search order is ptr, ptr+1, ..., wrapping through NREQ-1 back to ptr-1.
   // NOTE: every combinational output gets a default before the loop so no latch is inferred.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
   end

   assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
   assign wid_onehot = {{(NREQ-1){1'b0}}, 1'b1} << wid;
   assign busy       = (state != S_IDLE);

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         wid       <= '0;
         cnt       <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         res_a     <= '0;
         res_b     <= '0;
         txn_count <= '0;
      end else begin
         gnt <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  wid   <= win_idx;
                  res_a <= a_in[int'(win_idx)*WIDTH +: WIDTH];
                  res_b <= b_in[int'(win_idx)*WIDTH +: WIDTH];
                  gnt   <= win_onehot;
                  ptr   <= (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + PTR_W'(1);
                  cnt   <= 4'(LAT);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // The resource has settled for LAT cycles once cnt reaches 1.
               if (cnt == 4'd1) begin
                  rsp_data  <= res_y;
                  rsp_valid <= wid_onehot;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready[wid]) begin
                  rsp_valid <= '0;
                  txn_count <= txn_count + COUNT_W'(1);
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
